lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store unit controller for the MEM stage of the 64-bit core. It accepts one memory access at a time from the pipeline, stalls the pipeline while the access is outstanding, and drives a single valid/ready data-bus port. It generates byte-lane write data and strobes for stores. For loads, it captures the bus beat, then shifts, masks and sign- or zero-extends it before returning the result to writeback.

## Interface
Parameters:
- `TO_W`, 8: width of the response-timeout counter.
- `TO_MAX`, 200: number of cycles spent in WAIT before a timeout error is raised.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: the MEM stage presents an access.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 64: byte address.
- `req_load_type` in 3 (`LOAD_TYPE_BUS`): 001 lb, 010 lh, 011 lw, 100 ld, 101 lbu, 110 lhu, 111 lwu. Ignored for stores.
- `req_store_size` in 2: 00 sb, 01 sh, 10 sw, 11 sd. Ignored for loads.
- `req_wdata` in 64: store data, LSB-aligned.
- `req_ready` out 1: the request is accepted on `req_valid & req_ready`.
- `stall` out 1: freezes IF through MEM.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 64: extended load result; 0 for stores and errors.
- `resp_err` out 1: valid with `resp_valid`; set on misalignment, bus error or timeout.
- `bus_req_valid` out 1, `bus_req_ready` in 1: request handshake.
- `bus_addr` out 64: `{req_addr[63:3], 3'b000}`.
- `bus_we` out 1.
- `bus_wdata` out 64.
- `bus_wstrb` out 8.
- `bus_resp_valid` in 1, `bus_rdata` in 64, `bus_resp_err` in 1: response.

## Operation
- States:
  - IDLE: `req_ready` = 1.
  - REQ: drives `bus_req_valid`.
  - WAIT: awaits the bus response.
  - DONE: pulses `resp_valid`.
- IDLE transitions, on `req_valid`:
  - Latch `we`, address, type, size and data.
  - Misaligned access goes to DONE with error set and no bus activity. Misaligned means the address is not a multiple of the access size: half requires `addr[0]`=0, word requires `addr[1:0]`=0, double requires `addr[2:0]`=0.
  - An aligned access goes to REQ.
  - A load with `req_load_type` = 000 is treated as a no-op: go to DONE with no error.
- REQ: hold `bus_*` outputs stable until `bus_req_ready`, then go to WAIT and clear the timeout counter.
- WAIT:
  - `bus_resp_valid` goes to DONE. Capture `bus_rdata` for loads and latch `bus_resp_err` into the error flag.
  - Otherwise increment the counter. When the counter reaches `TO_MAX`, go to DONE with error set.
  - `bus_resp_valid` is ignored in every state other than WAIT.
- DONE: `resp_valid` = 1 for exactly one cycle, then IDLE. `req_ready` = 0 in DONE, so a new request waits one cycle.
- Store lanes:
  - `bus_wdata` = `wdata << (addr[2:0]*8)`.
  - `bus_wstrb` = `{0x01, 0x03, 0x0F, 0xFF}[size] << addr[2:0]`.
- Load extension:
  - `pre` = `(rdata >> addr[2:0]*8) & mask`, where mask is 0xFF, 0xFFFF, 0xFFFF_FFFF or all-ones for b, h, w, d.
  - For lb, lh and lw, OR `~mask` into the result when the top bit of `pre` is set.
  - For ld and the unsigned loads, the result is `pre` unchanged.
- `stall` = `(state==IDLE & req_valid) | state==REQ | state==WAIT`. It is low in DONE, so the pipeline advances on the completion cycle.
- Reset asserted in any state: return to IDLE immediately. Any in-flight bus transaction is abandoned and a late response is dropped because it arrives outside WAIT.

## Timing
- Reset values: state = IDLE, `req_ready`=1, and all other outputs (`stall`, `resp_*`, `bus_req_valid`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_wstrb`) = 0.
- `stall` is combinational from `req_valid` in IDLE.
- All other outputs are registered state or decode of latched fields.
- Minimum latency, counting the acceptance edge as cycle 0:
  - `bus_req_valid` in cycle 1.
  - Handshake in cycle 1 if `bus_req_ready` is high.
  - Earliest accepted response in cycle 2.
  - `resp_valid` in cycle 3.
- Misaligned access: `resp_valid` in cycle 1.
- Throughput: one access per 4 cycles at best.
- Timeout: `resp_err` appears `TO_MAX`+1 cycles after entering WAIT.

## Structure
- Add a `STORE_SIZE_BUS` define and the `LSU_IDLE/REQ/WAIT/DONE` state encodings to `defines.v`, alongside the existing `LOAD_TYPE_BUS`, `ADDR_LOW_BUS` and `DATA_BUS` defines.
- One sub-module, `lsu_load_ext`, contains the purely combinational shift/mask/extend logic (inputs: `addr_low`, `load_type`, `rdata`).
- FSM, latches, timeout counter and store-lane generation stay in `lsu_ctrl`.

## Test plan
- lb at address 0x1003, `bus_rdata` = 0x0000_0000_80FF_0000, `bus_req_ready` and response immediate → `resp_valid` in cycle 3, `resp_rdata` = 0xFFFF_FFFF_FFFF_FF80. The same access as lbu → 0x80.
- sh of 0xABCD at address 0x2006 → `bus_wdata` = 0xABCD_0000_0000_0000, `bus_wstrb` = 0xC0, `bus_we`=1, `bus_addr` = 0x2000.
- lw at address 0x3002 → `resp_valid`=1 with `resp_err`=1 in cycle 1, `bus_req_valid` never asserted, `stall`=1 only in cycle 0.
- `bus_req_ready` held low for 5 cycles → `bus_req_valid` and the `bus_*` outputs stay stable and `stall`=1 throughout. After the handshake, `bus_resp_err`=1 → `resp_err`=1.
- No response for `TO_MAX` cycles → `resp_valid` with `resp_err`=1, then back to IDLE. A later `bus_resp_valid` pulse is ignored.
- `rst_n` pulled low during WAIT → outputs return to their reset values asynchronously. After release, an ld to 0x4000 with `bus_rdata` = 0x8000_0000_0000_0001 returns exactly that value.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared types, FSM encodings and access-size helpers for the load/store unit.
// Encodings follow the pipeline's load-type and store-size bus formats.
package lsu_ctrl_pkg;

    localparam logic [1:0] LSU_IDLE = 2'd0;
    localparam logic [1:0] LSU_REQ  = 2'd1;
    localparam logic [1:0] LSU_WAIT = 2'd2;
    localparam logic [1:0] LSU_DONE = 2'd3;

    typedef enum logic [2:0] {
        LT_NONE = 3'b000,
        LT_LB   = 3'b001,
        LT_LH   = 3'b010,
        LT_LW   = 3'b011,
        LT_LD   = 3'b100,
        LT_LBU  = 3'b101,
        LT_LHU  = 3'b110,
        LT_LWU  = 3'b111
    } load_type_e;

    typedef enum logic [1:0] {
        SS_B = 2'b00,
        SS_H = 2'b01,
        SS_W = 2'b10,
        SS_D = 2'b11
    } store_size_e;

    // log2 of the access size in bytes, shared by loads and stores
    function automatic logic [1:0] access_log2(input logic we, input logic [2:0] lt,
                                               input logic [1:0] sz);
        logic [1:0] r;
        r = 2'd3;
        if (we) begin
            r = sz;
        end else begin
            case (lt)
                LT_LB, LT_LBU: r = 2'd0;
                LT_LH, LT_LHU: r = 2'd1;
                LT_LW, LT_LWU: r = 2'd2;
                default:       r = 2'd3;
            endcase
        end
        return r;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] a, input logic [1:0] log2sz);
        logic r;
        case (log2sz)
            2'd0:    r = 1'b0;
            2'd1:    r = a[0];
            2'd2:    r = |a[1:0];
            default: r = |a[2:0];
        endcase
        return r;
    endfunction

    function automatic logic [7:0] strb_base(input logic [1:0] sz);
        logic [7:0] r;
        case (sz)
            SS_B:    r = 8'h01;
            SS_H:    r = 8'h03;
            SS_W:    r = 8'h0F;
            default: r = 8'hFF;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Single valid/ready data-bus port between the LSU (master) and memory (slave).
interface lsu_ctrl_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [63:0] bus_addr;
    logic        bus_we;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_resp_valid;
    logic [63:0] bus_rdata;
    logic        bus_resp_err;

    modport master (
        output bus_req_valid, bus_addr, bus_we, bus_wdata, bus_wstrb,
        input  bus_req_ready, bus_resp_valid, bus_rdata, bus_resp_err
    );

    modport slave (
        input  bus_req_valid, bus_addr, bus_we, bus_wdata, bus_wstrb,
        output bus_req_ready, bus_resp_valid, bus_rdata, bus_resp_err
    );
endinterface

// File: rtl/lsu_load_ext.sv
// Combinational load alignment: shift the bus beat down to the addressed byte,
// mask to the access width and sign- or zero-extend.
module lsu_load_ext
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  addr_low,
    input  logic [2:0]  load_type,
    input  logic [63:0] rdata,
    output logic [63:0] result
);

    logic [63:0] shifted;
    logic [63:0] mask;
    logic [63:0] pre;
    logic        is_signed;
    logic        top_bit;

    always_comb begin
        shifted   = rdata >> {addr_low, 3'b000};
        mask      = 64'd0;
        is_signed = 1'b0;
        case (load_type)
            LT_LB:   begin mask = 64'h0000_0000_0000_00FF; is_signed = 1'b1; end
            LT_LH:   begin mask = 64'h0000_0000_0000_FFFF; is_signed = 1'b1; end
            LT_LW:   begin mask = 64'h0000_0000_FFFF_FFFF; is_signed = 1'b1; end
            LT_LD:   mask = 64'hFFFF_FFFF_FFFF_FFFF;
            LT_LBU:  mask = 64'h0000_0000_0000_00FF;
            LT_LHU:  mask = 64'h0000_0000_0000_FFFF;
            LT_LWU:  mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'd0;
        endcase
        pre = shifted & mask;
        case (load_type)
            LT_LB:   top_bit = pre[7];
            LT_LH:   top_bit = pre[15];
            LT_LW:   top_bit = pre[31];
            default: top_bit = 1'b0;
        endcase
        result = (is_signed && top_bit) ? (pre | ~mask) : pre;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store controller: one outstanding access, pipeline stall,
// store byte-lane generation, response timeout and load extension.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int TO_W   = 8,
    parameter int TO_MAX = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_load_type,
    input  logic [1:0]  req_store_size,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    lsu_ctrl_if.master  bus
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TO_MAX);

    logic [1:0]      state_q, state_d;
    logic            we_q, we_d;
    logic [63:0]     addr_q, addr_d;
    logic [2:0]      ltype_q, ltype_d;
    logic [1:0]      size_q, size_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [63:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [63:0]     ext_data;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        ltype_d = ltype_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    ltype_d = req_load_type;
                    size_d  = req_store_size;
                    wdata_d = req_wdata;
                    rdata_d = 64'd0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    // a load of type 000 completes as an error-free no-op
                    if (!req_we && req_load_type == LT_NONE) begin
                        state_d = LSU_DONE;
                    end else if (is_misaligned(req_addr[2:0],
                                 access_log2(req_we, req_load_type, req_store_size))) begin
                        state_d = LSU_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                if (bus.bus_req_ready) begin
                    state_d = LSU_WAIT;
                    cnt_d   = '0;
                end
            end
            LSU_WAIT: begin
                if (bus.bus_resp_valid) begin
                    state_d = LSU_DONE;
                    err_d   = bus.bus_resp_err;
                    if (!we_q) begin
                        rdata_d = bus.bus_rdata;
                    end
                end else if (cnt_q == TO_LIMIT) begin
                    state_d = LSU_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
            we_q    <= 1'b0;
            addr_q  <= 64'd0;
            ltype_q <= 3'd0;
            size_q  <= 2'd0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            ltype_q <= ltype_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    lsu_load_ext u_load_ext (
        .addr_low  (addr_q[2:0]),
        .load_type (ltype_q),
        .rdata     (rdata_q),
        .result    (ext_data)
    );

    assign req_ready  = (state_q == LSU_IDLE);
    assign stall      = ((state_q == LSU_IDLE) && req_valid) ||
                        (state_q == LSU_REQ) || (state_q == LSU_WAIT);
    assign resp_valid = (state_q == LSU_DONE);
    assign resp_err   = (state_q == LSU_DONE) && err_q;
    assign resp_rdata = ((state_q == LSU_DONE) && !we_q && !err_q) ? ext_data : 64'd0;

    // write lanes are decoded from the latched store only; loads drive zero lanes
    assign bus.bus_req_valid = (state_q == LSU_REQ);
    assign bus.bus_addr      = {addr_q[63:3], 3'b000};
    assign bus.bus_we        = we_q;
    assign bus.bus_wdata     = we_q ? (wdata_q << {addr_q[2:0], 3'b000}) : 64'd0;
    assign bus.bus_wstrb     = we_q ? (strb_base(size_q) << addr_q[2:0]) : 8'd0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a response scoreboard plus cycle-exact checks of
// latency, bus lanes, stall, timeout and asynchronous reset.
module tb_lsu_ctrl;

    localparam int TO_MAX = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [63:0] req_addr;
    logic [2:0]  req_load_type;
    logic [1:0]  req_store_size;
    logic [63:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;

    lsu_ctrl_if bus_if ();

    lsu_ctrl #(.TO_W(8), .TO_MAX(TO_MAX)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_load_type  (req_load_type),
        .req_store_size (req_store_size),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .stall          (stall),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .bus            (bus_if.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [63:0] data;
    } resp_t;

    resp_t sb_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag);
        resp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s_sb_empty: observed response with no expectation", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_err"}, {63'd0, resp_err}, {63'd0, e.err});
            check({tag, "_rdata"}, resp_rdata, e.data);
        end
    endtask

    // Drives one access starting in an IDLE cycle and checks every cycle until
    // the completion pulse; rdy_dly/rsp_dly insert bus back-pressure.
    task automatic access(input string tag, input logic we, input logic [63:0] addr,
                          input logic [2:0] lt, input logic [1:0] sz, input logic [63:0] wd,
                          input logic nobus, input int rdy_dly, input int rsp_dly,
                          input logic [63:0] brdata, input logic berr,
                          input logic exp_err, input logic [63:0] exp_data,
                          input logic [63:0] exp_wdata, input logic [7:0] exp_wstrb);
        resp_t e;
        check({tag, "_ready0"}, {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_load_type = lt; req_store_size = sz; req_wdata = wd;
        e.err = exp_err; e.data = exp_data;
        sb_q.push_back(e);
        #1;
        check({tag, "_stall0"}, {63'd0, stall}, 64'd1);
        step();
        req_valid = 1'b0; req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        if (nobus) begin
            check({tag, "_nobus"}, {63'd0, bus_if.bus_req_valid}, 64'd0);
            check({tag, "_rv1"}, {63'd0, resp_valid}, 64'd1);
            check({tag, "_stall1"}, {63'd0, stall}, 64'd0);
            pop_check(tag);
        end else begin
            for (int i = 0; i <= rdy_dly; i++) begin
                check({tag, "_breqv"}, {63'd0, bus_if.bus_req_valid}, 64'd1);
                check({tag, "_baddr"}, bus_if.bus_addr, {addr[63:3], 3'b000});
                check({tag, "_bwe"}, {63'd0, bus_if.bus_we}, {63'd0, we});
                if (we) begin
                    check({tag, "_bwdata"}, bus_if.bus_wdata, exp_wdata);
                    check({tag, "_bwstrb"}, {56'd0, bus_if.bus_wstrb}, {56'd0, exp_wstrb});
                end
                check({tag, "_stall_req"}, {63'd0, stall}, 64'd1);
                if (i == rdy_dly) bus_if.bus_req_ready = 1'b1;
                step();
            end
            bus_if.bus_req_ready = 1'b0;
            for (int j = 0; j <= rsp_dly; j++) begin
                check({tag, "_stall_wait"}, {63'd0, stall}, 64'd1);
                check({tag, "_rv_wait"}, {63'd0, resp_valid}, 64'd0);
                if (j == rsp_dly) begin
                    bus_if.bus_resp_valid = 1'b1;
                    bus_if.bus_rdata      = brdata;
                    bus_if.bus_resp_err   = berr;
                end
                step();
            end
            bus_if.bus_resp_valid = 1'b0;
            bus_if.bus_rdata      = 64'h5555_5555_5555_5555;
            bus_if.bus_resp_err   = 1'b0;
            check({tag, "_rv_done"}, {63'd0, resp_valid}, 64'd1);
            check({tag, "_stall_done"}, {63'd0, stall}, 64'd0);
            check({tag, "_ready_done"}, {63'd0, req_ready}, 64'd0);
            pop_check(tag);
        end
        $display("txn %s we=%0d addr=%h -> err=%0d rdata=%h", tag, we, addr, resp_err, resp_rdata);
        step();
        check({tag, "_idle_after"}, {63'd0, req_ready}, 64'd1);
        check({tag, "_rv_after"}, {63'd0, resp_valid}, 64'd0);
    endtask

    initial begin
        int cnt;
        resp_t e;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 64'd0;
        req_load_type = 3'd0; req_store_size = 2'd0; req_wdata = 64'd0;
        bus_if.bus_req_ready = 1'b0; bus_if.bus_resp_valid = 1'b0;
        bus_if.bus_rdata = 64'd0; bus_if.bus_resp_err = 1'b0;
        step(); step();
        check("rst_ready", {63'd0, req_ready}, 64'd1);
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_rv", {63'd0, resp_valid}, 64'd0);
        check("rst_breqv", {63'd0, bus_if.bus_req_valid}, 64'd0);
        check("rst_bwstrb", {56'd0, bus_if.bus_wstrb}, 64'd0);
        rst_n = 1'b1;
        step();

        // lb / lbu at 0x1003, minimum latency
        access("lb", 1'b0, 64'h1003, 3'b001, 2'd0, 64'd0, 1'b0, 0, 0,
               64'h0000_0000_80FF_0000, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 64'd0, 8'd0);
        access("lbu", 1'b0, 64'h1003, 3'b101, 2'd0, 64'd0, 1'b0, 0, 0,
               64'h0000_0000_80FF_0000, 1'b0, 1'b0, 64'h80, 64'd0, 8'd0);
        access("sh", 1'b1, 64'h2006, 3'b000, 2'b01, 64'hABCD, 1'b0, 0, 1,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'd0, 64'hABCD_0000_0000_0000, 8'hC0);
        access("lw_mis", 1'b0, 64'h3002, 3'b011, 2'd0, 64'd0, 1'b1, 0, 0,
               64'd0, 1'b0, 1'b1, 64'd0, 64'd0, 8'd0);
        access("sd_berr", 1'b1, 64'h5000, 3'b000, 2'b11, 64'h1122_3344_5566_7788, 1'b0, 5, 2,
               64'd0, 1'b1, 1'b1, 64'd0, 64'h1122_3344_5566_7788, 8'hFF);
        access("lh", 1'b0, 64'h6006, 3'b010, 2'd0, 64'd0, 1'b0, 1, 0,
               64'h8001_0000_0000_0000, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_8001, 64'd0, 8'd0);
        access("lhu", 1'b0, 64'h6006, 3'b110, 2'd0, 64'd0, 1'b0, 0, 0,
               64'h8001_0000_0000_0000, 1'b0, 1'b0, 64'h8001, 64'd0, 8'd0);
        access("lw", 1'b0, 64'h7004, 3'b011, 2'd0, 64'd0, 1'b0, 0, 3,
               64'h8000_0001_1234_5678, 1'b0, 1'b0, 64'hFFFF_FFFF_8000_0001, 64'd0, 8'd0);
        access("lwu", 1'b0, 64'h7004, 3'b111, 2'd0, 64'd0, 1'b0, 0, 0,
               64'h8000_0001_1234_5678, 1'b0, 1'b0, 64'h8000_0001, 64'd0, 8'd0);
        access("lw_pos", 1'b0, 64'h7000, 3'b011, 2'd0, 64'd0, 1'b0, 0, 0,
               64'h8000_0001_1234_5678, 1'b0, 1'b0, 64'h1234_5678, 64'd0, 8'd0);
        access("sb", 1'b1, 64'h8005, 3'b000, 2'b00, 64'h5A, 1'b0, 2, 0,
               64'd0, 1'b0, 1'b0, 64'd0, 64'h0000_5A00_0000_0000, 8'h20);
        access("sw", 1'b1, 64'h8004, 3'b000, 2'b10, 64'hCAFE_F00D, 1'b0, 0, 0,
               64'd0, 1'b0, 1'b0, 64'd0, 64'hCAFE_F00D_0000_0000, 8'hF0);
        access("sd_mis", 1'b1, 64'h4004, 3'b000, 2'b11, 64'h1, 1'b1, 0, 0,
               64'd0, 1'b0, 1'b1, 64'd0, 64'd0, 8'd0);
        access("sh_mis", 1'b1, 64'h4001, 3'b000, 2'b01, 64'h1, 1'b1, 0, 0,
               64'd0, 1'b0, 1'b1, 64'd0, 64'd0, 8'd0);
        access("ld_noop", 1'b0, 64'h4003, 3'b000, 2'd0, 64'd0, 1'b1, 0, 0,
               64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);

        // timeout: no response after the handshake
        req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h9000; req_load_type = 3'b100;
        e.err = 1'b1; e.data = 64'd0;
        sb_q.push_back(e);
        step();
        req_valid = 1'b0;
        bus_if.bus_req_ready = 1'b1;
        step();
        bus_if.bus_req_ready = 1'b0;
        cnt = 0;
        while (!resp_valid && cnt < TO_MAX + 10) begin
            step();
            cnt++;
        end
        check("timeout_lat", 64'(cnt), 64'(TO_MAX + 1));
        pop_check("timeout");
        $display("txn timeout addr=%h -> err=%0d after %0d cycles", 64'h9000, resp_err, cnt);
        step();
        bus_if.bus_resp_valid = 1'b1; bus_if.bus_rdata = 64'h1;
        step();
        bus_if.bus_resp_valid = 1'b0;
        check("late_rv", {63'd0, resp_valid}, 64'd0);
        check("late_ready", {63'd0, req_ready}, 64'd1);
        step();
        check("late_rv2", {63'd0, resp_valid}, 64'd0);

        // asynchronous reset while a store waits for its response
        req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h9108; req_store_size = 2'b11;
        req_wdata = 64'hFFFF_0000_FFFF_0000;
        step();
        req_valid = 1'b0;
        bus_if.bus_req_ready = 1'b1;
        step();
        bus_if.bus_req_ready = 1'b0;
        step();
        check("pre_rst_stall", {63'd0, stall}, 64'd1);
        check("pre_rst_bwe", {63'd0, bus_if.bus_we}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", {63'd0, req_ready}, 64'd1);
        check("arst_stall", {63'd0, stall}, 64'd0);
        check("arst_rv", {63'd0, resp_valid}, 64'd0);
        check("arst_err", {63'd0, resp_err}, 64'd0);
        check("arst_rdata", resp_rdata, 64'd0);
        check("arst_breqv", {63'd0, bus_if.bus_req_valid}, 64'd0);
        check("arst_bwe", {63'd0, bus_if.bus_we}, 64'd0);
        check("arst_baddr", bus_if.bus_addr, 64'd0);
        check("arst_bwdata", bus_if.bus_wdata, 64'd0);
        check("arst_bwstrb", {56'd0, bus_if.bus_wstrb}, 64'd0);
        $display("txn async_reset during WAIT");
        step();
        rst_n = 1'b1;
        step();
        bus_if.bus_resp_valid = 1'b1;
        step();
        bus_if.bus_resp_valid = 1'b0;
        check("post_rst_rv", {63'd0, resp_valid}, 64'd0);
        access("ld", 1'b0, 64'h4000, 3'b100, 2'd0, 64'd0, 1'b0, 0, 0,
               64'h8000_0000_0000_0001, 1'b0, 1'b0, 64'h8000_0000_0000_0001, 64'd0, 8'd0);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
